axi_lw_target: RTL and testbench
================================

AXI_LW_TARGET -- requirements
Module: axi_lw_target

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255; backend-ack wait limit in cycles; 8-bit counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 aw__valid, aw__id[11:0], aw__addr[31:0], aw__len[3:0], aw__size[2:0], aw__burst[1:0]  input  write-address channel; aw__lock/cache/prot/qos/region/user present, ignored.
REQ-005 awready  output  1  write address accepted.
REQ-006 w__valid, w__id[11:0], w__data[31:0], w__strb[3:0], w__last  input  write-data channel; w__user present, ignored.
REQ-007 wready  output  1  write beat accepted.
REQ-008 b__valid, b__id[11:0], b__resp[1:0], b__user[3:0]  output  write response; bready input 1.
REQ-009 ar__valid, ar__id[11:0], ar__addr[31:0], ar__len[3:0], ar__size[2:0], ar__burst[1:0]  input  read address; other ar__ fields ignored. arready output 1.
REQ-010 r__valid, r__id[11:0], r__data[31:0], r__resp[1:0], r__last, r__user[3:0]  output  read data; rready input 1.
REQ-011 req_valid, req_read, req_address[31:0], req_data[31:0], req_strb[3:0]  output  backend register-bus request.
REQ-012 resp_ack, resp_error  input  1 each; resp_data[31:0] input  backend completion.

Function
REQ-013 One transaction outstanding at a time; FSM states IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_DATA.
REQ-014 IDLE: awready/arready high, all other outputs low; when exactly one of aw__valid/ar__valid is high, that channel is accepted; when both are high, the channel not served last is accepted (after reset, write wins); the unaccepted ready drops the following cycle.
REQ-015 On accept, latch id, addr, len, burst, size; beat counter = len; error flag = (size != 2) or (burst not FIXED/INCR).
REQ-016 WR_DATA: wready high; on w__valid&wready latch data/strb, go WR_REQ; w__last and w__id ignored; beat count from len only.
REQ-017 WR_REQ / RD_REQ: if error flag set, skip backend and complete the beat immediately with SLVERR; else req_valid held high with stable fields until resp_ack; req_read = 1 for reads only.
REQ-018 Address advance per beat: INCR addr+4, wrapping modulo 2^32; FIXED unchanged.
REQ-019 Backend timeout: TIMEOUT_CYCLES cycles of req_valid without resp_ack complete the beat as SLVERR and drop req_valid.
REQ-020 Write: resp_error or timeout sets sticky burst error; after final beat -> WR_RESP with b__valid=1, b__id=latched id, b__resp=2'b10 if error, else 2'b00; hold until bready, then IDLE.
REQ-021 Read: on ack, r__data=resp_data, r__resp=2'b10 on resp_error/timeout/error flag (data 0), else 2'b00; r__id latched; r__last=1 on final beat; r__user=0; b__user=0.
REQ-022 RD_DATA: r__valid held, all r fields stable until rready; then next beat RD_REQ, or IDLE after final beat.
REQ-023 Earliest timing: handshake in IDLE at cycle N -> req_valid at N+1 (reads) or wready at N+1 (writes); ack at M -> r__valid at M+1.
REQ-024 A backend ack arriving the same cycle as timeout expiry is treated as success.

Reset
REQ-025 Reset in any state returns to IDLE next edge: awready=arready=1; wready, b__valid, r__valid, req_valid=0; all data/id outputs 0; priority -> write; in-flight transaction abandoned, no response issued.

Verification
REQ-026 Single write: aw addr 0x100 len 0 size 2 INCR, w data 0xDEADBEEF strb 0xF, ack after 3 cycles -> one req at 0x100 write, b__resp 0, b__id echoed.
REQ-027 Read burst: ar addr 0xFFFFFFF8 len 3 INCR, ack data k -> req addresses F8, FC, 0, 4; 4 r beats with r__last on 4th; rready low 5 cycles on beat 2 holds r stable.
REQ-028 Simultaneous aw/ar valid from reset -> write first, then read; repeat -> read first.
REQ-029 size=1 write len 1 -> no req_valid, two wready beats, b__resp 2'b10; FIXED read len 2 -> three reqs at same address.
REQ-030 No ack on read -> req_valid drops after 255 cycles, r__resp 2'b10, r__data 0; resp_error on beat 2 of write len 2 -> b__resp 2'b10.
REQ-031 Reset asserted mid read burst with r__valid high -> next cycle r__valid 0, awready=arready=1, no further req_valid.

Source files
------------

// File: rtl/axi_lw_target.sv
// AXI slave bridge to a simple register bus: one transaction at a time.
// Each beat becomes one backend request, bounded by a completion timeout.
module axi_lw_target #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aw__valid,
    input  logic [11:0] aw__id,
    input  logic [31:0] aw__addr,
    input  logic [3:0]  aw__len,
    input  logic [2:0]  aw__size,
    input  logic [1:0]  aw__burst,
    input  logic        aw__lock,
    input  logic [3:0]  aw__cache,
    input  logic [2:0]  aw__prot,
    input  logic [3:0]  aw__qos,
    input  logic [3:0]  aw__region,
    input  logic [3:0]  aw__user,
    output logic        awready,
    input  logic        w__valid,
    input  logic [11:0] w__id,
    input  logic [31:0] w__data,
    input  logic [3:0]  w__strb,
    input  logic        w__last,
    input  logic [3:0]  w__user,
    output logic        wready,
    output logic        b__valid,
    output logic [11:0] b__id,
    output logic [1:0]  b__resp,
    output logic [3:0]  b__user,
    input  logic        bready,
    input  logic        ar__valid,
    input  logic [11:0] ar__id,
    input  logic [31:0] ar__addr,
    input  logic [3:0]  ar__len,
    input  logic [2:0]  ar__size,
    input  logic [1:0]  ar__burst,
    input  logic        ar__lock,
    input  logic [3:0]  ar__cache,
    input  logic [2:0]  ar__prot,
    input  logic [3:0]  ar__qos,
    input  logic [3:0]  ar__region,
    input  logic [3:0]  ar__user,
    output logic        arready,
    output logic        r__valid,
    output logic [11:0] r__id,
    output logic [31:0] r__data,
    output logic [1:0]  r__resp,
    output logic        r__last,
    output logic [3:0]  r__user,
    input  logic        rready,
    output logic        req_valid,
    output logic        req_read,
    output logic [31:0] req_address,
    output logic [31:0] req_data,
    output logic [3:0]  req_strb,
    input  logic        resp_ack,
    input  logic        resp_error,
    input  logic [31:0] resp_data
);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [11:0] id_q;
    logic [31:0] addr_q;
    logic [3:0]  beats_q;
    logic [1:0]  burst_q;
    logic        err_flag_q;
    logic        sticky_err_q;
    logic        prio_wr_q;
    logic [7:0]  tmo_cnt_q;

    logic        tmo_hit;
    logic        req_done;
    logic        beat_err;
    logic        unused_inputs;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

    function automatic logic cfg_error(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    // An ack in the expiry cycle wins: beat_err only reports timeout when no ack is present.
    assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
    assign req_done = err_flag_q || resp_ack || tmo_hit;
    assign beat_err = err_flag_q || !resp_ack || resp_error;

    assign b__user = 4'd0;
    assign r__user = 4'd0;

    assign unused_inputs = ^{aw__lock, aw__cache, aw__prot, aw__qos, aw__region, aw__user,
                             ar__lock, ar__cache, ar__prot, ar__qos, ar__region, ar__user,
                             w__id, w__last, w__user};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            awready      <= 1'b1;
            arready      <= 1'b1;
            wready       <= 1'b0;
            b__valid     <= 1'b0;
            b__id        <= '0;
            b__resp      <= '0;
            r__valid     <= 1'b0;
            r__id        <= '0;
            r__data      <= '0;
            r__resp      <= '0;
            r__last      <= 1'b0;
            req_valid    <= 1'b0;
            req_read     <= 1'b0;
            req_address  <= '0;
            req_data     <= '0;
            req_strb     <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            beats_q      <= '0;
            burst_q      <= '0;
            err_flag_q   <= 1'b0;
            sticky_err_q <= 1'b0;
            prio_wr_q    <= 1'b1;
            tmo_cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw__valid && (!ar__valid || prio_wr_q)) begin
                        id_q         <= aw__id;
                        addr_q       <= aw__addr;
                        beats_q      <= aw__len;
                        burst_q      <= aw__burst;
                        err_flag_q   <= cfg_error(aw__size, aw__burst);
                        sticky_err_q <= 1'b0;
                        prio_wr_q    <= 1'b0;
                        awready      <= 1'b0;
                        arready      <= 1'b0;
                        wready       <= 1'b1;
                        state        <= WR_DATA;
                    end else if (ar__valid) begin
                        id_q        <= ar__id;
                        addr_q      <= ar__addr;
                        beats_q     <= ar__len;
                        burst_q     <= ar__burst;
                        err_flag_q  <= cfg_error(ar__size, ar__burst);
                        prio_wr_q   <= 1'b1;
                        awready     <= 1'b0;
                        arready     <= 1'b0;
                        req_valid   <= !cfg_error(ar__size, ar__burst);
                        req_read    <= 1'b1;
                        req_address <= ar__addr;
                        tmo_cnt_q   <= '0;
                        state       <= RD_REQ;
                    end
                end
                WR_DATA: begin
                    if (w__valid) begin
                        wready      <= 1'b0;
                        req_valid   <= !err_flag_q;
                        req_read    <= 1'b0;
                        req_address <= addr_q;
                        req_data    <= w__data;
                        req_strb    <= w__strb;
                        tmo_cnt_q   <= '0;
                        state       <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (req_done) begin
                        req_valid    <= 1'b0;
                        req_address  <= '0;
                        req_data     <= '0;
                        req_strb     <= '0;
                        sticky_err_q <= sticky_err_q || beat_err;
                        if (beats_q == 4'd0) begin
                            b__valid <= 1'b1;
                            b__id    <= id_q;
                            b__resp  <= (sticky_err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state    <= WR_RESP;
                        end else begin
                            beats_q <= beats_q - 4'd1;
                            addr_q  <= next_addr(addr_q, burst_q);
                            wready  <= 1'b1;
                            state   <= WR_DATA;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        b__valid <= 1'b0;
                        b__id    <= '0;
                        b__resp  <= '0;
                        awready  <= 1'b1;
                        arready  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (req_done) begin
                        req_valid   <= 1'b0;
                        req_read    <= 1'b0;
                        req_address <= '0;
                        r__valid    <= 1'b1;
                        r__id       <= id_q;
                        r__data     <= beat_err ? 32'd0 : resp_data;
                        r__resp     <= beat_err ? RESP_SLVERR : RESP_OKAY;
                        r__last     <= (beats_q == 4'd0);
                        state       <= RD_DATA;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        r__valid <= 1'b0;
                        r__id    <= '0;
                        r__data  <= '0;
                        r__resp  <= '0;
                        r__last  <= 1'b0;
                        if (beats_q == 4'd0) begin
                            awready <= 1'b1;
                            arready <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            beats_q     <= beats_q - 4'd1;
                            addr_q      <= next_addr(addr_q, burst_q);
                            req_address <= next_addr(addr_q, burst_q);
                            req_valid   <= !err_flag_q;
                            req_read    <= 1'b1;
                            tmo_cnt_q   <= '0;
                            state       <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lw_target.sv
// Scoreboard bench for axi_lw_target: directed transactions push expected
// backend requests and B/R responses; independent monitors pop and compare.
module tb_axi_lw_target;

    logic        clk;
    logic        reset;
    logic        aw__valid;
    logic [11:0] aw__id;
    logic [31:0] aw__addr;
    logic [3:0]  aw__len;
    logic [2:0]  aw__size;
    logic [1:0]  aw__burst;
    logic        awready;
    logic        w__valid;
    logic [31:0] w__data;
    logic [3:0]  w__strb;
    logic        w__last;
    logic        wready;
    logic        b__valid;
    logic [11:0] b__id;
    logic [1:0]  b__resp;
    logic [3:0]  b__user;
    logic        bready;
    logic        ar__valid;
    logic [11:0] ar__id;
    logic [31:0] ar__addr;
    logic [3:0]  ar__len;
    logic [2:0]  ar__size;
    logic [1:0]  ar__burst;
    logic        arready;
    logic        r__valid;
    logic [11:0] r__id;
    logic [31:0] r__data;
    logic [1:0]  r__resp;
    logic        r__last;
    logic [3:0]  r__user;
    logic        rready;
    logic        req_valid;
    logic        req_read;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        resp_ack;
    logic        resp_error;
    logic [31:0] resp_data;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          delay;
        bit          err;
        logic [31:0] rdata;
        bit          noack;
    } req_t;

    typedef struct {
        logic [11:0] id;
        logic [1:0]  resp;
    } b_t;

    typedef struct {
        logic [11:0] id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    req_t req_q[$];
    b_t   b_q[$];
    r_t   r_q[$];

    int checks = 0;
    int errors = 0;
    int r_pops = 0;
    int r_stall_at = -1;
    bit r_hold_all = 0;

    axi_lw_target #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .aw__valid(aw__valid), .aw__id(aw__id), .aw__addr(aw__addr), .aw__len(aw__len),
        .aw__size(aw__size), .aw__burst(aw__burst), .aw__lock(1'b0), .aw__cache(4'd0),
        .aw__prot(3'd0), .aw__qos(4'd0), .aw__region(4'd0), .aw__user(4'd0),
        .awready(awready),
        .w__valid(w__valid), .w__id(12'd0), .w__data(w__data), .w__strb(w__strb),
        .w__last(w__last), .w__user(4'd0), .wready(wready),
        .b__valid(b__valid), .b__id(b__id), .b__resp(b__resp), .b__user(b__user), .bready(bready),
        .ar__valid(ar__valid), .ar__id(ar__id), .ar__addr(ar__addr), .ar__len(ar__len),
        .ar__size(ar__size), .ar__burst(ar__burst), .ar__lock(1'b0), .ar__cache(4'd0),
        .ar__prot(3'd0), .ar__qos(4'd0), .ar__region(4'd0), .ar__user(4'd0),
        .arready(arready),
        .r__valid(r__valid), .r__id(r__id), .r__data(r__data), .r__resp(r__resp),
        .r__last(r__last), .r__user(r__user), .rready(rready),
        .req_valid(req_valid), .req_read(req_read), .req_address(req_address),
        .req_data(req_data), .req_strb(req_strb),
        .resp_ack(resp_ack), .resp_error(resp_error), .resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_req(bit rd, logic [31:0] addr, logic [31:0] data, int delay,
                                     bit err, logic [31:0] rdata, bit noack);
        req_t e;
        e.rd = rd; e.addr = addr; e.data = data; e.strb = 4'hF; e.delay = delay;
        e.err = err; e.rdata = rdata; e.noack = noack;
        req_q.push_back(e);
    endfunction

    function automatic void push_b(logic [11:0] id, logic [1:0] resp);
        b_t e;
        e.id = id; e.resp = resp;
        b_q.push_back(e);
    endfunction

    function automatic void push_r(logic [11:0] id, logic [31:0] data, logic [1:0] resp, logic last);
        r_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endfunction

    // Backend model: checks each new request and answers according to its plan.
    initial begin
        req_t e;
        int   cnt;
        resp_ack = 0; resp_error = 0; resp_data = '0;
        forever begin
            @(negedge clk);
            if (req_valid) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", {31'd0, req_valid, req_address}, 64'd0);
                end else begin
                    e = req_q.pop_front();
                    check("req_read", req_read, e.rd);
                    check("req_addr", req_address, e.addr);
                    if (!e.rd) begin
                        check("req_data", req_data, e.data);
                        check("req_strb", req_strb, e.strb);
                    end
                    if (e.noack) begin
                        cnt = 0;
                        while (req_valid && cnt < 1000) begin
                            cnt++;
                            @(negedge clk);
                        end
                        check("timeout_len", cnt, 255);
                    end else begin
                        repeat (e.delay) @(negedge clk);
                        @(posedge clk);
                        #1;
                        resp_ack = 1; resp_error = e.err; resp_data = e.rdata;
                        @(posedge clk);
                        #1;
                        resp_ack = 0; resp_error = 0; resp_data = '0;
                    end
                end
            end
        end
    end

    // Write-response monitor; bready stays high.
    initial begin
        b_t e;
        bready = 1;
        forever begin
            @(negedge clk);
            if (b__valid) begin
                if (b_q.size() == 0) begin
                    check("unexpected_b", {52'd0, b__id}, 64'hFFFF);
                end else begin
                    e = b_q.pop_front();
                    check("b_id", b__id, e.id);
                    check("b_resp", b__resp, e.resp);
                    check("b_user", b__user, 4'd0);
                end
            end
        end
    end

    // Read-data monitor: drives rready, optionally stalls one beat, checks stability.
    initial begin
        r_t          e;
        int          stalled;
        bit          have_prev;
        logic [46:0] prev;
        stalled = 0; have_prev = 0; prev = '0;
        rready = 1;
        forever begin
            @(negedge clk);
            if (r_hold_all) begin
                rready = 0;
                have_prev = 0;
            end else if (r__valid) begin
                if (have_prev) check("r_stable", {r__id, r__data, r__resp, r__last}, prev);
                if (r_pops == r_stall_at && stalled < 5) begin
                    rready = 0;
                    stalled++;
                    prev = {r__id, r__data, r__resp, r__last};
                    have_prev = 1;
                end else begin
                    rready = 1;
                    have_prev = 0;
                    stalled = 0;
                    if (r_q.size() == 0) begin
                        check("unexpected_r", {52'd0, r__id}, 64'hFFFF);
                    end else begin
                        e = r_q.pop_front();
                        check("r_id", r__id, e.id);
                        check("r_data", r__data, e.data);
                        check("r_resp", r__resp, e.resp);
                        check("r_last", r__last, e.last);
                        check("r_user", r__user, 4'd0);
                    end
                    r_pops++;
                end
            end else begin
                rready = 1;
            end
        end
    end

    task automatic aw_set(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        aw__id = id; aw__addr = addr; aw__len = len; aw__size = size; aw__burst = burst;
        aw__valid = 1;
    endtask

    task automatic ar_set(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        ar__id = id; ar__addr = addr; ar__len = len; ar__size = size; ar__burst = burst;
        ar__valid = 1;
    endtask

    task automatic aw_hs();
        int n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 1000);
        check("aw_ready_wait", awready, 1'b1);
        @(posedge clk);
        #1 aw__valid = 0;
    endtask

    task automatic ar_hs();
        int n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 1000);
        check("ar_ready_wait", arready, 1'b1);
        @(posedge clk);
        #1 ar__valid = 0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic last);
        int n = 0;
        w__data = data; w__strb = 4'hF; w__last = last; w__valid = 1;
        do begin @(negedge clk); n++; end while (!wready && n < 1000);
        check("w_ready_wait", wready, 1'b1);
        @(posedge clk);
        #1 w__valid = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 2000 && !(req_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0
                             && awready && arready)) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 2000), 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        aw__valid = 0; aw__id = '0; aw__addr = '0; aw__len = '0; aw__size = '0; aw__burst = '0;
        ar__valid = 0; ar__id = '0; ar__addr = '0; ar__len = '0; ar__size = '0; ar__burst = '0;
        w__valid = 0; w__data = '0; w__strb = '0; w__last = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", b__valid, 1'b0);
        check("rst_rvalid", r__valid, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_outputs", {b__id, r__id, r__data, r__last}, 64'd0);
        reset = 0;

        // Contention from reset: write, then read, then write; a fresh pair then favours read.
        push_req(0, 32'h200, 32'h1111_0000, 0, 0, 0, 0);
        push_b(12'h011, 2'b00);
        aw_set(12'h011, 32'h200, 4'd0, 3'd2, 2'b01);
        ar_set(12'h022, 32'h300, 4'd0, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        check("arb1_write_wready", wready, 1'b1);
        check("arb1_arready_drop", arready, 1'b0);
        push_req(1, 32'h300, 0, 0, 0, 32'h3333, 0);
        push_r(12'h022, 32'h3333, 2'b00, 1'b1);
        push_req(0, 32'h208, 32'h2222, 0, 0, 0, 0);
        push_b(12'h012, 2'b00);
        aw_set(12'h012, 32'h208, 4'd0, 3'd2, 2'b01);
        w_send(32'h1111_0000, 1);
        ar_hs();
        check("arb2_read_req", {req_valid, req_read, wready}, 3'b110);
        aw_hs();
        check("arb3_write_wready", wready, 1'b1);
        w_send(32'h2222, 1);
        wait_done("arb_sequence_done");

        push_req(1, 32'h304, 0, 0, 0, 32'h4444, 0);
        push_r(12'h023, 32'h4444, 2'b00, 1'b1);
        push_req(0, 32'h20C, 32'h5555, 0, 0, 0, 0);
        push_b(12'h013, 2'b00);
        aw_set(12'h013, 32'h20C, 4'd0, 3'd2, 2'b01);
        ar_set(12'h023, 32'h304, 4'd0, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        check("arb4_read_first", {req_valid, req_read, wready}, 3'b110);
        ar__valid = 0;
        aw_hs();
        w_send(32'h5555, 1);
        wait_done("arb_repeat_done");

        // Single write, ack after a short delay.
        push_req(0, 32'h100, 32'hDEADBEEF, 3, 0, 0, 0);
        push_b(12'h05A, 2'b00);
        aw_set(12'h05A, 32'h100, 4'd0, 3'd2, 2'b01);
        aw_hs();
        w_send(32'hDEADBEEF, 1);
        wait_done("single_write_done");

        // INCR read burst wrapping past 2^32, second beat stalled by rready.
        for (int k = 0; k < 4; k++) begin
            push_req(1, 32'hFFFF_FFF8 + 32'(4 * k), 0, 0, 0, 32'hA0 + 32'(k), 0);
            push_r(12'h077, 32'hA0 + 32'(k), 2'b00, (k == 3));
        end
        r_stall_at = r_pops + 1;
        ar_set(12'h077, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01);
        ar_hs();
        wait_done("read_burst_done");
        r_stall_at = -1;

        // Unsupported size on a write: no backend traffic, SLVERR.
        push_b(12'h031, 2'b10);
        aw_set(12'h031, 32'h400, 4'd1, 3'd1, 2'b01);
        aw_hs();
        w_send(32'h0A, 0);
        w_send(32'h0B, 1);
        wait_done("size_err_write_done");

        // FIXED read: same address each beat; backend error on the last beat.
        push_req(1, 32'h500, 0, 1, 0, 32'h11, 0);
        push_req(1, 32'h500, 0, 1, 0, 32'h22, 0);
        push_req(1, 32'h500, 0, 1, 1, 32'h33, 0);
        push_r(12'h041, 32'h11, 2'b00, 1'b0);
        push_r(12'h041, 32'h22, 2'b00, 1'b0);
        push_r(12'h041, 32'h0, 2'b10, 1'b1);
        ar_set(12'h041, 32'h500, 4'd2, 3'd2, 2'b00);
        ar_hs();
        wait_done("fixed_read_done");

        // WRAP burst read is rejected without a backend request.
        push_r(12'h042, 32'h0, 2'b10, 1'b1);
        ar_set(12'h042, 32'h580, 4'd0, 3'd2, 2'b10);
        ar_hs();
        wait_done("wrap_read_done");

        // Read with no ack times out.
        push_req(1, 32'h600, 0, 0, 0, 0, 1);
        push_r(12'h051, 32'h0, 2'b10, 1'b1);
        ar_set(12'h051, 32'h600, 4'd0, 3'd2, 2'b01);
        ar_hs();
        wait_done("timeout_read_done");

        // Ack landing in the final timeout cycle counts as success.
        push_req(1, 32'h640, 0, 253, 0, 32'hCAFEF00D, 0);
        push_r(12'h052, 32'hCAFEF00D, 2'b00, 1'b1);
        ar_set(12'h052, 32'h640, 4'd0, 3'd2, 2'b01);
        ar_hs();
        wait_done("ack_at_expiry_done");

        // Three-beat write with backend error on beat 2.
        push_req(0, 32'h700, 32'hD0, 0, 0, 0, 0);
        push_req(0, 32'h704, 32'hD1, 0, 1, 0, 0);
        push_req(0, 32'h708, 32'hD2, 0, 0, 0, 0);
        push_b(12'h061, 2'b10);
        aw_set(12'h061, 32'h700, 4'd2, 3'd2, 2'b01);
        aw_hs();
        w_send(32'hD0, 0);
        w_send(32'hD1, 0);
        w_send(32'hD2, 1);
        wait_done("err_write_done");

        // Reset in the middle of a read burst while r__valid is held.
        r_hold_all = 1;
        push_req(1, 32'h800, 0, 0, 0, 32'h88, 0);
        ar_set(12'h071, 32'h800, 4'd3, 3'd2, 2'b01);
        ar_hs();
        begin
            int n = 0;
            while (!r__valid && n < 100) begin @(negedge clk); n++; end
        end
        check("rst_mid_pre_rvalid", r__valid, 1'b1);
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1;
        check("rst_mid_rvalid", r__valid, 1'b0);
        check("rst_mid_readies", {awready, arready}, 2'b11);
        check("rst_mid_req_valid", req_valid, 1'b0);
        check("rst_mid_rfields", {r__id, r__data, r__last}, 64'd0);
        reset = 0;
        r_hold_all = 0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_idle", {awready, arready, req_valid, r__valid}, 4'b1100);

        check("req_q_empty", req_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        check("r_q_empty", r_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
